mem_stage: RTL

- Pipeline MEM stage, directly downstream of the EX stage and upstream of WB.
- Consumes the EX payload and waits for the data-SRAM response of any load EX issued.
- Buffers that response when WB stalls, then aligns and extends the load data.
- Merges exceptions, feeds the forwarding path, and drops stale responses after a flush.

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage_load_align.sv | 24 ++
 rtl/mem_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus field offsets and payload layouts for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned E2M_W   = 84;
  localparam int unsigned M2W_W   = 77;
  localparam int unsigned M_RFC_W = 39;

  localparam int unsigned LD_OP_LSB = 78;
  localparam int unsigned LD_OP_W   = 5;
  localparam int unsigned EXC_LSB   = 71;
  localparam int unsigned EXC_W     = 7;

  typedef struct packed {
    logic ld_w;
    logic ld_h;
    logic ld_hu;
    logic ld_b;
    logic ld_bu;
  } ld_op_t;

  typedef struct packed {
    logic             req_issued;
    ld_op_t           ld_op;
    logic [EXC_W-1:0] except;
    logic             res_from_mem;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      result;
    logic [31:0]      pc;
  } es_to_ms_t;

  typedef struct packed {
    logic [EXC_W-1:0] except;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      final_result;
    logic [31:0]      pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        ld_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
  } ms_rfc_t;

endpackage

// File: rtl/mem_stage_if.sv
// Valid/allowin pipeline link carrying a W-bit payload between stages.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int unsigned W = E2M_W
);
  logic         valid;
  logic [W-1:0] bus;
  logic         allowin;

  modport master (output valid, output bus, input allowin);
  modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/half/word of a load response.
module load_align
  import mem_stage_pkg::*;
(
  input  ld_op_t      ld_op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{off, 3'b000} +: 8];
    sel_half = off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    if (ld_op.ld_b)       data = {{24{sel_byte[7]}}, sel_byte};
    else if (ld_op.ld_bu) data = {24'b0, sel_byte};
    else if (ld_op.ld_h)  data = {{16{sel_half[15]}}, sel_half};
    else if (ld_op.ld_hu) data = {16'b0, sel_half};
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: waits for load data, buffers it across WB stalls,
// aligns it, and discards responses belonging to flushed loads.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned CANCEL_W = 2
)(
  input  logic               clk,
  input  logic               resetn,
  mem_stage_if.slave         es_to_ms,
  mem_stage_if.master        ms_to_ws,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  output logic [M_RFC_W-1:0] ms_rf_collect,
  output logic [EXC_W-1:0]   ms_except,
  input  logic               except_flush
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

  logic                ms_valid;
  logic [E2M_W-1:0]    es_bus_q;
  es_to_ms_t           es_q;
  logic                rbuf_valid;
  logic [31:0]         rbuf_data;
  logic [CANCEL_W-1:0] cancel_cnt;

  logic        need_wait;
  logic        data_ok_live;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic        rbuf_set;
  logic        cancel_inc;
  logic        cancel_dec;
  ld_op_t      ld_op;
  logic [31:0] ld_raw;
  logic [31:0] ld_data;
  logic [31:0] final_result;
  ms_to_ws_t   ws_bus;
  ms_rfc_t     rfc;

  assign es_q  = es_bus_q;
  assign ld_op = es_bus_q[LD_OP_LSB +: LD_OP_W];

  assign need_wait      = es_q.res_from_mem & es_q.req_issued & ~|es_bus_q[EXC_LSB +: EXC_W];
  // A response counts only once every stale one owed to a flushed load has drained.
  assign data_ok_live   = data_sram_data_ok & (cancel_cnt == '0);
  assign ms_ready_go    = ~need_wait | rbuf_valid | data_ok_live;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ms_to_ws.allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~except_flush;

  assign rbuf_set   = data_ok_live & ms_valid & need_wait & ~rbuf_valid & ~ms_to_ws.allowin;
  assign cancel_inc = except_flush & ms_valid & need_wait & ~rbuf_valid & ~data_ok_live;
  assign cancel_dec = data_sram_data_ok & (cancel_cnt != '0);

  assign ld_raw = rbuf_valid ? rbuf_data : data_sram_rdata;

  load_align u_load_align (
    .ld_op (ld_op),
    .off   (es_q.result[1:0]),
    .rdata (ld_raw),
    .data  (ld_data)
  );

  assign final_result = need_wait ? ld_data : es_q.result;

  always_comb begin
    ws_bus              = '0;
    ws_bus.except       = es_q.except;
    ws_bus.rf_we        = es_q.rf_we;
    ws_bus.rf_waddr     = es_q.rf_waddr;
    ws_bus.final_result = final_result;
    ws_bus.pc           = es_q.pc;
  end

  always_comb begin
    rfc              = '0;
    rfc.ld_pending   = ms_valid & need_wait & ~ms_ready_go;
    rfc.rf_we        = es_q.rf_we & ms_valid;
    rfc.rf_waddr     = es_q.rf_waddr;
    rfc.final_result = final_result;
  end

  assign es_to_ms.allowin = ms_allowin;
  assign ms_to_ws.valid   = ms_to_ws_valid;
  assign ms_to_ws.bus     = ws_bus;
  assign ms_rf_collect    = rfc;
  assign ms_except        = es_q.except & {EXC_W{ms_valid}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      es_bus_q <= '0;
    end else begin
      if (except_flush)    ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms.valid;
      if (es_to_ms.valid && ms_allowin) es_bus_q <= es_to_ms.bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf_valid <= 1'b0;
      rbuf_data  <= '0;
    end else begin
      if (except_flush)                          rbuf_valid <= 1'b0;
      else if (ms_to_ws_valid && ms_to_ws.allowin) rbuf_valid <= 1'b0;
      else if (rbuf_set)                         rbuf_valid <= 1'b1;
      if (rbuf_set) rbuf_data <= data_sram_rdata;
    end
  end

  // Flush and a discarded response in the same cycle cancel each other out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_cnt <= '0;
    end else if (cancel_inc && !cancel_dec) begin
      if (cancel_cnt != CANCEL_MAX) cancel_cnt <= cancel_cnt + 1'b1;
    end else if (!cancel_inc && cancel_dec) begin
      cancel_cnt <= cancel_cnt - 1'b1;
    end
  end

endmodule
